// File: rtl/dac_pacer_pkg.sv
// dac_pacer_pkg: shared types and constants for the DAC sample pacer.
package dac_pacer_pkg;

  localparam int unsigned DAC_DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } pacer_state_t;

endpackage

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: small circular sample buffer with a combinational head read.
// The pointers wrap modulo DEPTH. DEPTH must be a power of two, at least 2.
// A push and a pop in the same cycle are both accepted, including when full.
module dac_sample_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Storage array: written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy; power-of-two depth makes the pointer wrap implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: buffers core-written samples and releases one to the DAC
// every div+1 clocks once the FIFO has been primed to PRIME_LVL entries.
// Optional build macro DAC_PACER_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_cnt output; without it the port and counter are absent.
module dac_sample_pacer
  import dac_pacer_pkg::*;
#(
  parameter int unsigned DATA_W    = DAC_DATA_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned PRIME_LVL = 4
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       div,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic [DATA_W-1:0]      D,
  output logic                   sample_strobe,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun
`ifdef DAC_PACER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] PRIME_THR = PRIME_LVL[LVL_W-1:0];

  pacer_state_t      state;
  pacer_state_t      state_next;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  cnt_next;
  logic              tick;
  logic              push;
  logic              pop;
  logic              underrun_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign wr_ready = !fifo_full;
  assign push     = wr_valid && !fifo_full;
  assign tick     = (cnt >= div);

  dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next state, tick counter and pop/underrun decisions.
  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    pop          = 1'b0;
    underrun_set = 1'b0;
    if (!enable) begin
      // Enable drop wins over a coincident tick: no pop, counter cleared.
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  state_next = PRIME;
        PRIME: if (fifo_level >= PRIME_THR) state_next = RUN;
        RUN: begin
          cnt_next = cnt + 1'b1;
          if (tick) begin
            cnt_next = '0;
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              underrun_set = 1'b1;
              state_next   = PRIME;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and sample-period counter registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // DAC output register and the pulses aligned with its update.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      D             <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (pop) D <= fifo_rdata;
      sample_strobe <= pop;
      underrun      <= underrun_set;
    end
  end

`ifdef DAC_PACER_UNDERRUN_CNT_EN
  // Saturating underrun event counter, cleared only by reset.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (underrun_set && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer: self-checking bench for dac_sample_pacer with a
// queue-based reference model of the pacing rules.
module tb_dac_sample_pacer;

  localparam int DATA_W    = 10;
  localparam int DEPTH     = 8;
  localparam int DIV_W     = 16;
  localparam int PRIME_LVL = 4;
  localparam int LVL_W     = 4;
  localparam int M_OFF  = 0;
  localparam int M_ARM  = 1;
  localparam int M_PLAY = 2;

  logic              CLK = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [DIV_W-1:0]  div = '0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic [DATA_W-1:0] D;
  logic              sample_strobe;
  logic [LVL_W-1:0]  fifo_level;
  logic              underrun;
`ifdef DAC_PACER_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO as a queue, playback mode, edges left to next tick.
  int m_q[$];
  int m_mode;
  int m_left;
  int m_d;
  bit m_strobe;
  bit m_under;
`ifdef DAC_PACER_UNDERRUN_CNT_EN
  int m_ucnt;
`endif

  logic [DATA_W+LVL_W+2:0] obs;
  assign obs = {D, sample_strobe, underrun, fifo_level, wr_ready};

  dac_sample_pacer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .DIV_W     (DIV_W),
    .PRIME_LVL (PRIME_LVL)
  ) dut (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .enable        (enable),
    .div           (div),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .D             (D),
    .sample_strobe (sample_strobe),
    .fifo_level    (fifo_level),
    .underrun      (underrun)
`ifdef DAC_PACER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt  (underrun_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DATA_W+LVL_W+2:0] exp_vec();
    return {DATA_W'(m_d), m_strobe, m_under, LVL_W'(m_q.size()), (m_q.size() < DEPTH)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode   = M_OFF;
    m_left   = 0;
    m_d      = 0;
    m_strobe = 0;
    m_under  = 0;
`ifdef DAC_PACER_UNDERRUN_CNT_EN
    m_ucnt   = 0;
`endif
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    int  sz;
    bit  accept;
    sz       = m_q.size();
    accept   = wr_valid && (sz < DEPTH);
    m_strobe = 0;
    m_under  = 0;
    if (!enable) begin
      m_mode = M_OFF;
    end else if (m_mode == M_OFF) begin
      m_mode = M_ARM;
    end else if (m_mode == M_ARM) begin
      if (sz >= PRIME_LVL) begin
        m_mode = M_PLAY;
        m_left = int'(div) + 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (sz > 0) begin
          m_d      = m_q.pop_front();
          m_strobe = 1;
          m_left   = int'(div) + 1;
        end else begin
          m_under = 1;
          m_mode  = M_ARM;
`ifdef DAC_PACER_UNDERRUN_CNT_EN
          if (m_ucnt < 65535) m_ucnt++;
`endif
        end
      end
    end
    if (accept) m_q.push_back(int'(wr_data));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    model_reset();
    #7;
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bit hit;
    int strobes;
    reset_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; div = '0;
    model_reset();
    #12;
    n_cmp++;
    if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
    @(negedge CLK);
    reset_n = 1'b1;
    div = DIV_W'(3);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = DATA_W'($urandom);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_fill: got %h want %h", obs, exp_vec()); end
    end
    wr_valid = 1'b0; enable = 1'b1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_run: got %h want %h", obs, exp_vec()); end
      hit = m_strobe;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL reset_first_strobe: got none want strobe within 40 cycles"); end
    // Asynchronous reset in the middle of a RUN period with 3 samples queued.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({D, fifo_level, wr_ready} !== {10'h000, 4'd0, 1'b1}) begin
      n_bad++; $display("FAIL reset_async: got D=%h lvl=%0d rdy=%b want D=000 lvl=0 rdy=1", D, fifo_level, wr_ready);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_after: got %h want %h", obs, exp_vec()); end
      if (sample_strobe) strobes++;
    end
    n_cmp++;
    if (strobes != 0) begin n_bad++; $display("FAIL reset_no_strobe: got %0d strobes want 0", strobes); end
  endtask

  task automatic test_pattern();
    logic [DATA_W-1:0] pat [4];
    logic [DATA_W-1:0] seen [$];
    int                when [$];
    int                unders;
    pat[0] = 10'h000; pat[1] = 10'h155; pat[2] = 10'h2AA; pat[3] = 10'h3FF;
    do_reset();
    div = DIV_W'(3);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = pat[i];
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL pattern_fill: got %h want %h", obs, exp_vec()); end
    end
    wr_valid = 1'b0; enable = 1'b1;
    unders = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL pattern_run: got %h want %h", obs, exp_vec()); end
      if (sample_strobe) begin seen.push_back(D); when.push_back(c); end
      if (underrun) unders++;
    end
    n_cmp++;
    if (seen.size() != 4) begin n_bad++; $display("FAIL pattern_count: got %0d strobes want 4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      n_cmp++;
      if (seen[i] !== pat[i]) begin n_bad++; $display("FAIL pattern_data%0d: got %h want %h", i, seen[i], pat[i]); end
    end
    for (int i = 1; i < when.size(); i++) begin
      n_cmp++;
      if (when[i] - when[i-1] != 4) begin n_bad++; $display("FAIL pattern_gap%0d: got %0d want 4", i, when[i] - when[i-1]); end
    end
    n_cmp++;
    if (unders != 1) begin n_bad++; $display("FAIL pattern_underrun: got %0d pulses want 1", unders); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = DATA_W'($urandom);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL full_fill: got %h want %h", obs, exp_vec()); end
    end
    n_cmp++;
    if (wr_ready !== 1'b0 || fifo_level !== 4'd8) begin
      n_bad++; $display("FAIL full_flags: got rdy=%b lvl=%0d want rdy=0 lvl=8", wr_ready, fifo_level);
    end
    wr_valid = 1'b1; wr_data = 10'h3FF;
    step();
    wr_valid = 1'b0;
    n_cmp++;
    if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL full_drop: got lvl=%0d want 8", fifo_level); end
    div = DIV_W'($urandom_range(0, 2));
    enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL full_drain: got %h want %h", obs, exp_vec()); end
    end
  endtask

  task automatic test_div0_stream();
    int strobes;
    int unders;
    int lvl_bad;
    do_reset();
    div = '0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = DATA_W'($urandom);
      step();
    end
    wr_valid = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6 && m_mode != M_PLAY; i++) step();
    n_cmp++;
    if (m_mode != M_PLAY || obs !== exp_vec()) begin
      n_bad++; $display("FAIL div0_start: got %h want %h (mode %0d)", obs, exp_vec(), m_mode);
    end
    strobes = 0; unders = 0; lvl_bad = 0;
    for (int c = 0; c < 30; c++) begin
      wr_valid = 1'b1; wr_data = DATA_W'($urandom);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL div0_run: got %h want %h", obs, exp_vec()); end
      if (sample_strobe) strobes++;
      if (underrun) unders++;
      if (fifo_level !== 4'd4) lvl_bad++;
    end
    wr_valid = 1'b0;
    n_cmp++;
    if (strobes != 30 || unders != 0 || lvl_bad != 0) begin
      n_bad++; $display("FAIL div0_summary: got strobes=%0d underruns=%0d lvl_changes=%0d want 30/0/0", strobes, unders, lvl_bad);
    end
  endtask

  task automatic test_enable_pause();
    bit                hit;
    int                strobes;
    logic [DATA_W-1:0] held;
    do_reset();
    div = DIV_W'(2);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = DATA_W'($urandom);
      step();
    end
    wr_valid = 1'b0; enable = 1'b1;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL pause_start: got %h want %h", obs, exp_vec()); end
      hit = m_strobe;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL pause_first_strobe: got none want strobe within 30 cycles"); end
    held = DATA_W'(m_d);
    enable = 1'b0;
    strobes = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL pause_off: got %h want %h", obs, exp_vec()); end
      if (sample_strobe || D !== held) strobes++;
    end
    enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL pause_prime: got %h want %h", obs, exp_vec()); end
      if (sample_strobe || D !== held) strobes++;
    end
    n_cmp++;
    if (strobes != 0) begin n_bad++; $display("FAIL pause_hold: got %0d strobe/D changes want 0", strobes); end
    wr_valid = 1'b1; wr_data = DATA_W'($urandom);
    step();
    wr_valid = 1'b0;
    strobes = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL pause_resume: got %h want %h", obs, exp_vec()); end
      if (sample_strobe) strobes++;
    end
    n_cmp++;
    if (strobes != 4) begin n_bad++; $display("FAIL pause_resume_count: got %0d strobes want 4", strobes); end
  endtask

  task automatic test_random();
    int pct;
    do_reset();
    div = DIV_W'($urandom_range(0, 4));
    pct = 50;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) pct = $urandom_range(10, 90);
      if ($urandom_range(0, 39) == 0) begin
        enable = !enable;
        if (!enable) div = DIV_W'($urandom_range(0, 4));
      end
      wr_valid = ($urandom_range(0, 99) < pct);
      wr_data  = DATA_W'($urandom);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL random_c%0d: got %h want %h", c, obs, exp_vec()); end
    end
    wr_valid = 1'b0;
  endtask

`ifdef DAC_PACER_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    bit hit;
    do_reset();
    div = DIV_W'(1);
    for (int n = 0; n < 3; n++) begin
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
        wr_valid = 1'b1; wr_data = DATA_W'($urandom);
        step();
      end
      wr_valid = 1'b0;
      hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
        step();
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL ucnt_run: got %h want %h", obs, exp_vec()); end
        hit = m_under;
      end
      n_cmp++;
      if (!hit) begin n_bad++; $display("FAIL ucnt_force%0d: got no underrun want one within 60 cycles", n); end
    end
    n_cmp++;
    if (underrun_cnt !== 16'd3 || int'(underrun_cnt) != m_ucnt) begin
      n_bad++; $display("FAIL ucnt_value: got %0d want 3", underrun_cnt);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (underrun_cnt !== 16'd3) begin n_bad++; $display("FAIL ucnt_hold: got %0d want 3", underrun_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_pattern();
    test_full();
    test_div0_stream();
    test_enable_pause();
    test_random();
`ifdef DAC_PACER_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
